// File: rtl/data_mem_ctrl.sv
// Data-memory sequencer for the BF core: shares the single-port DataMemory between the core,
// a whole-memory clear engine and a single-cycle host debug port.
module data_mem_ctrl #(
    parameter int unsigned DATA_ADDR_SIZE = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0]  CLEAR_VALUE    = 8'h00
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_ADDR_SIZE-1:0] core_cursor,
    input  logic [7:0]                core_write_val,
    input  logic                      core_write_enable,
    output logic [7:0]                core_read_val,
    output logic                      core_enable,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [DATA_ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]                host_wdata,
    output logic                      host_ack,
    output logic [7:0]                host_rdata,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic [DATA_ADDR_SIZE-1:0] mem_cursor,
    output logic [7:0]                mem_write_val,
    output logic                      mem_write_enable,
    input  logic [7:0]                mem_read_val
);

    typedef enum logic [1:0] {StClear, StCore, StHost} state_e;

    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StCore;

    state_e                    state_q;
    logic [DATA_ADDR_SIZE-1:0] clr_addr_q;
    logic                      clr_pend_q;
    logic                      clear_done_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ResetState;
            clr_addr_q   <= '0;
            clr_pend_q   <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            unique case (state_q)
                StClear: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (&clr_addr_q) begin
                        state_q      <= StCore;
                        clear_done_q <= 1'b1;
                    end
                end
                StCore: begin
                    // A pending or fresh clear outranks the host.
                    if (clear_start || clr_pend_q) begin
                        state_q    <= StClear;
                        clr_pend_q <= 1'b0;
                    end else if (host_req) begin
                        state_q <= StHost;
                    end
                end
                StHost: begin
                    // Always hand one cycle back to the core; remember a clear seen meanwhile.
                    state_q <= StCore;
                    if (clear_start) begin
                        clr_pend_q <= 1'b1;
                    end
                end
                default: state_q <= ResetState;
            endcase
        end
    end

    // Strobes are also gated by reset so they drop the moment reset asserts.
    always_comb begin
        core_enable      = 1'b0;
        host_ack         = 1'b0;
        clear_busy       = 1'b0;
        mem_cursor       = core_cursor;
        mem_write_val    = core_write_val;
        mem_write_enable = 1'b0;
        unique case (state_q)
            StClear: begin
                mem_cursor       = clr_addr_q;
                mem_write_val    = CLEAR_VALUE;
                mem_write_enable = reset;
                clear_busy       = 1'b1;
            end
            StCore: begin
                core_enable      = reset;
                mem_write_enable = core_write_enable & reset;
            end
            StHost: begin
                mem_cursor       = host_addr;
                mem_write_val    = host_wdata;
                mem_write_enable = host_we & reset;
                host_ack         = reset;
            end
            default: begin
                core_enable = 1'b0;
            end
        endcase
    end

    assign core_read_val = mem_read_val;
    assign host_rdata    = mem_read_val;
    assign clear_done    = clear_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a 16-cell memory model; one instance clears on reset,
// a second instance does not.
module tb_data_mem_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] core_cursor;
    logic [7:0] core_write_val;
    logic       core_write_enable;
    logic [7:0] core_read_val;
    logic       core_enable;
    logic       host_req;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       clear_start;
    logic       clear_busy;
    logic       clear_done;
    logic [3:0] mem_cursor;
    logic [7:0] mem_write_val;
    logic       mem_write_enable;
    logic [7:0] mem_read_val;

    logic [7:0] core_read_val0;
    logic       core_enable0;
    logic       host_ack0;
    logic [7:0] host_rdata0;
    logic       clear_busy0;
    logic       clear_done0;
    logic [3:0] mem_cursor0;
    logic [7:0] mem_write_val0;
    logic       mem_write_enable0;
    logic [7:0] mem_read_val0;

    logic       preload;
    logic [7:0] mem1 [16];
    logic [7:0] mem0 [16];

    int n_vec = 0;
    int n_err = 0;

    data_mem_ctrl #(
        .DATA_ADDR_SIZE(4),
        .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE   (8'h00)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .core_cursor      (core_cursor),
        .core_write_val   (core_write_val),
        .core_write_enable(core_write_enable),
        .core_read_val    (core_read_val),
        .core_enable      (core_enable),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_ack         (host_ack),
        .host_rdata       (host_rdata),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done),
        .mem_cursor       (mem_cursor),
        .mem_write_val    (mem_write_val),
        .mem_write_enable (mem_write_enable),
        .mem_read_val     (mem_read_val)
    );

    data_mem_ctrl #(
        .DATA_ADDR_SIZE(4),
        .CLEAR_ON_RESET(1'b0),
        .CLEAR_VALUE   (8'h00)
    ) u_dut0 (
        .clock            (clock),
        .reset            (reset),
        .core_cursor      (4'd1),
        .core_write_val   (8'h00),
        .core_write_enable(1'b0),
        .core_read_val    (core_read_val0),
        .core_enable      (core_enable0),
        .host_req         (1'b0),
        .host_we          (1'b0),
        .host_addr        (4'd0),
        .host_wdata       (8'h00),
        .host_ack         (host_ack0),
        .host_rdata       (host_rdata0),
        .clear_start      (1'b0),
        .clear_busy       (clear_busy0),
        .clear_done       (clear_done0),
        .mem_cursor       (mem_cursor0),
        .mem_write_val    (mem_write_val0),
        .mem_write_enable (mem_write_enable0),
        .mem_read_val     (mem_read_val0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 8'hAA;
                mem0[i] <= 8'h55;
            end
        end else begin
            if (mem_write_enable) mem1[mem_cursor] <= mem_write_val;
            if (mem_write_enable0) mem0[mem_cursor0] <= mem_write_val0;
        end
    end

    assign mem_read_val  = mem1[mem_cursor];
    assign mem_read_val0 = mem0[mem_cursor0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " core_enable"}, core_enable, 1'b0);
        chk({tag, " host_ack"}, host_ack, 1'b0);
        chk({tag, " mem_write_enable"}, mem_write_enable, 1'b0);
        chk({tag, " clear_busy"}, clear_busy, 1'b1);
        chk({tag, " clear_done"}, clear_done, 1'b0);
        chk({tag, " dut0 core_enable"}, core_enable0, 1'b0);
        chk({tag, " dut0 clear_busy"}, clear_busy0, 1'b0);
    endtask

    // Sixteen clear cycles followed by the clear_done cycle; inputs are left as the caller set them.
    task automatic run_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            #1;
            chk($sformatf("%s clr%0d busy", tag, i), clear_busy, 1'b1);
            chk($sformatf("%s clr%0d core_enable", tag, i), core_enable, 1'b0);
            chk($sformatf("%s clr%0d host_ack", tag, i), host_ack, 1'b0);
            chk($sformatf("%s clr%0d mem_we", tag, i), mem_write_enable, 1'b1);
            chk($sformatf("%s clr%0d cursor", tag, i), mem_cursor, i[3:0]);
            chk($sformatf("%s clr%0d wval", tag, i), mem_write_val, 8'h00);
            chk($sformatf("%s clr%0d done", tag, i), clear_done, 1'b0);
        end
        @(negedge clock);
        #1;
        chk({tag, " done pulse"}, clear_done, 1'b1);
        chk({tag, " done core_enable"}, core_enable, 1'b1);
        chk({tag, " done busy"}, clear_busy, 1'b0);
        chk({tag, " done host_ack"}, host_ack, 1'b0);
    endtask

    typedef struct {
        logic       hreq;
        logic       hwe;
        logic [3:0] haddr;
        logic [7:0] hwd;
        logic [3:0] ccur;
        logic [7:0] cwv;
        logic       cwe;
        logic       en;
        logic       ack;
        logic       mwe;
        logic [3:0] mcur;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs [15];

    initial begin
        // hreq hwe haddr hwd    ccur cwv   cwe  | en ack mwe mcur rd
        vecs[0]  = '{1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 4'd3, 8'h00, 4'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 4'd3, 8'h00, 4'd5, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 8'h37};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 8'h00, 4'd6, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 8'h00};
        for (int k = 4; k < 14; k++) begin
            if (k % 2 == 0)
                vecs[k] = '{1'b1, 1'b0, 4'd6, 8'h00, 4'd9, 8'hEE, 1'b1,
                            1'b1, 1'b0, 1'b1, 4'd9, 8'h00};
            else
                vecs[k] = '{1'b1, 1'b0, 4'd6, 8'h00, 4'd9, 8'hEE, 1'b1,
                            1'b0, 1'b1, 1'b0, 4'd6, 8'h11};
        end
        vecs[14] = '{1'b0, 1'b0, 4'd0, 8'h00, 4'd9, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00};

        reset             = 1'b1;
        preload           = 1'b1;
        core_cursor       = '0;
        core_write_val    = '0;
        core_write_enable = 1'b0;
        host_req          = 1'b0;
        host_we           = 1'b0;
        host_addr         = '0;
        host_wdata        = '0;
        clear_start       = 1'b0;

        // Reset with memories preloaded
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk_reset_outputs("rst");
        @(posedge clock);
        #1;
        preload = 1'b0;
        reset   = 1'b1;
        #1;
        chk("dut0 first core_enable", core_enable0, 1'b1);
        chk("dut0 first busy", clear_busy0, 1'b0);

        run_clear("t1");
        @(negedge clock);
        #1;
        chk("t1 done single pulse", clear_done, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t1 mem[%0d]", i), mem1[i], 8'h00);
            chk($sformatf("t6 mem0[%0d]", i), mem0[i], 8'h55);
        end
        chk("t6 dut0 clear_done", clear_done0, 1'b0);
        chk("t6 dut0 host_ack", host_ack0, 1'b0);

        // Core write, host read, then a host holding its request
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            host_req          = vecs[k].hreq;
            host_we           = vecs[k].hwe;
            host_addr         = vecs[k].haddr;
            host_wdata        = vecs[k].hwd;
            core_cursor       = vecs[k].ccur;
            core_write_val    = vecs[k].cwv;
            core_write_enable = vecs[k].cwe;
            #1;
            chk($sformatf("v%0d core_enable", k), core_enable, vecs[k].en);
            chk($sformatf("v%0d host_ack", k), host_ack, vecs[k].ack);
            chk($sformatf("v%0d mem_we", k), mem_write_enable, vecs[k].mwe);
            chk($sformatf("v%0d mem_cursor", k), mem_cursor, vecs[k].mcur);
            if (vecs[k].ack) begin
                chk($sformatf("v%0d host_rdata", k), host_rdata, vecs[k].rd);
                chk($sformatf("v%0d core_read_val", k), core_read_val, vecs[k].rd);
            end
        end
        chk("t2 mem[3]", mem1[3], 8'h37);
        chk("t3 mem[6]", mem1[6], 8'h11);
        chk("t3 mem[9]", mem1[9], 8'hEE);

        // clear_start seen during a host write
        @(negedge clock);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd2;
        host_wdata = 8'h5A;
        #1;
        chk("t4 core before host", core_enable, 1'b1);
        @(negedge clock);
        clear_start = 1'b1;
        #1;
        chk("t4 host ack", host_ack, 1'b1);
        chk("t4 host mem_we", mem_write_enable, 1'b1);
        chk("t4 host cursor", mem_cursor, 4'd2);
        chk("t4 host busy", clear_busy, 1'b0);
        @(negedge clock);
        clear_start = 1'b0;
        host_we     = 1'b0;
        #1;
        chk("t4 mem[2] written", mem1[2], 8'h5A);
        chk("t4 core gap enable", core_enable, 1'b1);
        chk("t4 core gap ack", host_ack, 1'b0);
        chk("t4 core gap busy", clear_busy, 1'b0);
        run_clear("t4");
        @(negedge clock);
        #1;
        chk("t4 host ack after clear", host_ack, 1'b1);
        chk("t4 host rdata after clear", host_rdata, 8'h00);
        chk("t4 done cleared", clear_done, 1'b0);
        @(negedge clock);
        host_req = 1'b0;
        #1;
        chk("t4 back to core", core_enable, 1'b1);

        // Reset in the middle of a clear
        @(negedge clock);
        clear_start = 1'b1;
        #1;
        chk("t5 start cycle busy", clear_busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            clear_start = 1'b0;
            #1;
            chk($sformatf("t5 pre clr%0d cursor", i), mem_cursor, i[3:0]);
            chk($sformatf("t5 pre clr%0d busy", i), clear_busy, 1'b1);
        end
        reset   = 1'b0;
        preload = 1'b1;
        #1;
        chk_reset_outputs("t5 rst");
        @(posedge clock);
        #1;
        preload = 1'b0;
        reset   = 1'b1;
        run_clear("t5");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t5 mem[%0d]", i), mem1[i], 8'h00);
        end
        chk("t6 dut0 read val", core_read_val0, 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
